mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 16, meaning the maximum number of cycles spent in WAIT before a bus error is flagged.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; asynchronous and active-low.
REQ-004 SHALL have port write, input, 1, pipeline register enable.
REQ-005 SHALL have port flush, input, 1, which kills the current instruction.
REQ-006 SHALL have inputs from EXE: pc 32, exe_data 32 (address or result), busB 32 (store data), memReadEn 4, memWriteEn 4, load_signed 1, mem_to_reg 1, reg_wen 1, reg_num 5, cp0_wen 1, cp0_num 5, cp0_sel 3, overflow 1, Int 1, bad_inst 1, bc_inst 2.
REQ-007 SHALL have data-memory ports: dm_req out 1, dm_addr out 32, dm_we out 4, dm_wdata out 32, dm_ack in 1, dm_rdata in 32.
REQ-008 SHALL have output stall_out, 1, which holds upstream stages.
REQ-009 SHALL have registered outputs to WB: pc_out 32, wb_data_out 32, reg_wen_out 1, reg_num_out 5, cp0_wen_out 1, cp0_num_out 5, cp0_sel_out 3, overflow_out 1, Int_out 1, bad_inst_out 1, bc_inst_out 2, addr_err_out 1, bus_err_out 1.

Function
REQ-010 Access size SHALL be taken from the mask: 4'b1111 is a word, 4'b0011 a half, 4'b0001 a byte; any other nonzero mask is treated as a word.
REQ-011 addr_err SHALL be 1 for a word access with exe_data[1:0]!=0 or a half access with exe_data[0]!=0 (combinational).
REQ-012 mem_op SHALL be 1 when (memReadEn|memWriteEn)!=0 and addr_err, flush and overflow are all 0.
REQ-013 dm_addr SHALL be {exe_data[31:2],2'b00}.
REQ-014 dm_we SHALL be memWriteEn shifted left by exe_data[1:0], forced to 0 when not a write.
REQ-015 dm_wdata SHALL be busB replicated per size: byte as {4{busB[7:0]}}, half as {2{busB[15:0]}}, word as busB.
REQ-016 FSM states SHALL be IDLE and WAIT.
- IDLE: dm_req=mem_op. On mem_op&&dm_ack, stay in IDLE (zero-wait access). On mem_op&&!dm_ack, go to WAIT.
- WAIT: dm_req=1 with address, enables and data held stable. On dm_ack, go to IDLE. When the counter reaches MAX_WAIT-1 without ack, go to IDLE and set the bus-error flag.
REQ-017 The wait counter SHALL clear on entry to WAIT and increment each cycle spent in WAIT.
REQ-018 stall_out SHALL be (IDLE&&mem_op&&!dm_ack) || (WAIT&&!dm_ack&&!timeout).
REQ-019 Upstream SHALL hold its inputs stable while stall_out=1.
REQ-020 Load formatting SHALL select the lane by exe_data[1:0] for bytes and exe_data[1] for halves, then sign-extend if load_signed, else zero-extend.
REQ-021 wb_data_out source SHALL be the formatted dm_rdata when mem_to_reg, else exe_data.
REQ-022 Output register update, on a rising edge with write=1 and stall_out=0:
- Load all outputs from the current inputs.
- reg_wen_out = reg_wen & !flush & !overflow & !addr_err & !buserr.
- cp0_wen_out uses the same gating.
REQ-023 While stall_out=1, the output register SHALL load a bubble: all outputs 0.
REQ-024 With write=0 and stall_out=0, the output register SHALL hold its value.
REQ-025 A flush asserted while in WAIT SHALL NOT cancel the bus transaction; the access completes, and the resulting output is written with reg_wen_out=0 and cp0_wen_out=0.
REQ-026 On timeout, the output SHALL be registered with bus_err_out=1, reg_wen_out=0 and wb_data_out=exe_data.
REQ-027 A dm_ack received while in IDLE with mem_op=0 SHALL be ignored.

Reset
REQ-028 When rst=0, asynchronously: state=IDLE, counter=0, dm_req=0, and every registered output = 0.
REQ-029 While rst=0, stall_out SHALL be 0 and dm_we SHALL be 0.
REQ-030 Reset asserted mid-WAIT SHALL abandon the transaction; dm_req SHALL drop immediately.
REQ-031 After rst rises, the first mem_op SHALL be issued from IDLE.

Verification
REQ-032 The bench SHALL cover a zero-wait signed byte load:
- Stimulus: exe_data=0x1003, memReadEn=0001, load_signed=1, mem_to_reg=1, dm_rdata=0x80xxxxxx, dm_ack same cycle.
- Required response: stall_out=0; next edge wb_data_out=0xFFFFFF80, reg_wen_out=1.
REQ-033 The bench SHALL cover a half store with a 3-cycle ack:
- Stimulus: exe_data=0x2002, memWriteEn=0011, busB=0x1234ABCD.
- Required response: dm_we=1100, dm_wdata=0xABCDABCD; stall_out=1 for 3 cycles, 3 bubbles out; then a normal output.
REQ-034 The bench SHALL cover a misaligned word:
- Stimulus: exe_data=0x0002, memReadEn=1111.
- Required response: dm_req=0; next edge addr_err_out=1, reg_wen_out=0.
REQ-035 The bench SHALL cover a timeout with MAX_WAIT=4 and dm_ack held 0.
- Required response: dm_req high 5 cycles in total (1 IDLE, 4 WAIT), then bus_err_out=1, reg_wen_out=0, state=IDLE.
REQ-036 The bench SHALL cover a flush during WAIT: ack after 2 cycles.
- Required response: the output has reg_wen_out=0 and dm_req stays high until the ack.
REQ-037 The bench SHALL cover reset mid-WAIT: rst=0 in cycle 2 of WAIT.
- Required response: dm_req=0 immediately, outputs=0; after release, a word load to 0x40 completes normally.

Source files
------------

// File: rtl/mem_stage_if.sv
// Data-memory request/ack bus between the MEM stage and memory.
// The stage drives the request; memory answers with ack and read data.
interface mem_stage_if;
  logic        req;
  logic [31:0] addr;
  logic [3:0]  we;
  logic [31:0] wdata;
  logic        ack;
  logic [31:0] rdata;

  modport master (
    output req, addr, we, wdata,
    input  ack, rdata
  );

  modport slave (
    input  req, addr, we, wdata,
    output ack, rdata
  );
endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage: issues data-memory accesses, waits for ack
// with a bounded timeout, formats loads and registers the WB bundle.
module mem_stage #(
  parameter int MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        write,
  input  logic        flush,
  input  logic [31:0] pc,
  input  logic [31:0] exe_data,
  input  logic [31:0] busB,
  input  logic [3:0]  memReadEn,
  input  logic [3:0]  memWriteEn,
  input  logic        load_signed,
  input  logic        mem_to_reg,
  input  logic        reg_wen,
  input  logic [4:0]  reg_num,
  input  logic        cp0_wen,
  input  logic [4:0]  cp0_num,
  input  logic [2:0]  cp0_sel,
  input  logic        overflow,
  input  logic        Int,
  input  logic        bad_inst,
  input  logic [1:0]  bc_inst,
  mem_stage_if.master dm,
  output logic        stall_out,
  output logic [31:0] pc_out,
  output logic [31:0] wb_data_out,
  output logic        reg_wen_out,
  output logic [4:0]  reg_num_out,
  output logic        cp0_wen_out,
  output logic [4:0]  cp0_num_out,
  output logic [2:0]  cp0_sel_out,
  output logic        overflow_out,
  output logic        Int_out,
  output logic        bad_inst_out,
  output logic [1:0]  bc_inst_out,
  output logic        addr_err_out,
  output logic        bus_err_out
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] wb;
    logic        reg_wen;
    logic [4:0]  reg_num;
    logic        cp0_wen;
    logic [4:0]  cp0_num;
    logic [2:0]  cp0_sel;
    logic        overflow;
    logic        intr;
    logic        bad_inst;
    logic [1:0]  bc_inst;
    logic        addr_err;
    logic        bus_err;
  } wb_t;

  state_t      state, state_n;
  logic [CW-1:0] cnt;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  we_q;
  logic        flush_q;

  logic [3:0]  mask;
  logic        access, is_byte, is_half, is_word;
  logic        addr_err, mem_op, timeout, kill;
  logic [31:0] addr_c, wdata_c, ld;
  logic [3:0]  we_c;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  wb_t         out_q, out_d;

  assign mask    = (|memWriteEn) ? memWriteEn : memReadEn;
  assign access  = |(memReadEn | memWriteEn);
  assign is_byte = mask == 4'b0001;
  assign is_half = mask == 4'b0011;
  assign is_word = access && !is_byte && !is_half;

  assign addr_err = (is_word && |exe_data[1:0])
                 || (is_half && exe_data[0]);
  assign mem_op   = access && !addr_err && !flush && !overflow;

  assign addr_c = {exe_data[31:2], 2'b00};
  assign we_c   = (|memWriteEn) ? memWriteEn << exe_data[1:0]
                                : 4'b0000;

  always_comb begin
    wdata_c = busB;
    unique case (1'b1)
      is_byte: wdata_c = {4{busB[7:0]}};
      is_half: wdata_c = {2{busB[15:0]}};
      default: wdata_c = busB;
    endcase
  end

  assign timeout = (state == WAIT) && !dm.ack
                && (cnt == CW'(MAX_WAIT - 1));

  always_comb begin
    stall_out = 1'b0;
    if (rst) begin
      stall_out = (state == IDLE && mem_op && !dm.ack)
               || (state == WAIT && !dm.ack && !timeout);
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (mem_op && !dm.ack) state_n = WAIT;
      WAIT: if (dm.ack || timeout) state_n = IDLE;
    endcase
  end

  // In WAIT the request comes from the captured copy, so a late
  // flush cannot disturb an access that is already on the bus.
  always_comb begin
    dm.req   = 1'b0;
    dm.addr  = addr_c;
    dm.we    = 4'b0000;
    dm.wdata = wdata_c;
    if (rst) begin
      unique case (state)
        IDLE: begin
          dm.req = mem_op;
          if (mem_op) dm.we = we_c;
        end
        WAIT: begin
          dm.req   = 1'b1;
          dm.addr  = addr_q;
          dm.we    = we_q;
          dm.wdata = wdata_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      we_q    <= '0;
      wdata_q <= '0;
      flush_q <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE) begin
        cnt     <= '0;
        flush_q <= 1'b0;
        if (mem_op) begin
          addr_q  <= addr_c;
          we_q    <= we_c;
          wdata_q <= wdata_c;
        end
      end else begin
        cnt     <= cnt + 1'b1;
        flush_q <= flush_q | flush;
      end
    end
  end

  always_comb begin
    lane_b = dm.rdata[7:0];
    unique case (exe_data[1:0])
      2'd0: lane_b = dm.rdata[7:0];
      2'd1: lane_b = dm.rdata[15:8];
      2'd2: lane_b = dm.rdata[23:16];
      2'd3: lane_b = dm.rdata[31:24];
    endcase
    lane_h = exe_data[1] ? dm.rdata[31:16]
                         : dm.rdata[15:0];
    ld = dm.rdata;
    unique case (1'b1)
      is_byte: ld = load_signed ? {{24{lane_b[7]}}, lane_b}
                                : {24'h0, lane_b};
      is_half: ld = load_signed ? {{16{lane_h[15]}}, lane_h}
                                : {16'h0, lane_h};
      default: ld = dm.rdata;
    endcase
  end

  assign kill = flush || (state == WAIT && flush_q)
             || overflow || addr_err || timeout;

  always_comb begin
    out_d          = '0;
    out_d.pc       = pc;
    out_d.wb       = (mem_to_reg && !timeout) ? ld : exe_data;
    out_d.reg_wen  = reg_wen && !kill;
    out_d.reg_num  = reg_num;
    out_d.cp0_wen  = cp0_wen && !kill;
    out_d.cp0_num  = cp0_num;
    out_d.cp0_sel  = cp0_sel;
    out_d.overflow = overflow;
    out_d.intr     = Int;
    out_d.bad_inst = bad_inst;
    out_d.bc_inst  = bc_inst;
    out_d.addr_err = addr_err;
    out_d.bus_err  = timeout;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           out_q <= '0;
    else if (stall_out) out_q <= '0;
    else if (write)     out_q <= out_d;
  end

  assign pc_out       = out_q.pc;
  assign wb_data_out  = out_q.wb;
  assign reg_wen_out  = out_q.reg_wen;
  assign reg_num_out  = out_q.reg_num;
  assign cp0_wen_out  = out_q.cp0_wen;
  assign cp0_num_out  = out_q.cp0_num;
  assign cp0_sel_out  = out_q.cp0_sel;
  assign overflow_out = out_q.overflow;
  assign Int_out      = out_q.intr;
  assign bad_inst_out = out_q.bad_inst;
  assign bc_inst_out  = out_q.bc_inst;
  assign addr_err_out = out_q.addr_err;
  assign bus_err_out  = out_q.bus_err;

endmodule

// File: tb/tb_mem_stage.sv
// Randomized scoreboard bench for mem_stage with a memory responder
// and a byte-level reference model of loads, stores and timeouts.
module tb_mem_stage;
  localparam int MAXW = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] wb;
    logic        rw;
    logic [4:0]  rn;
    logic        cw;
    logic [4:0]  cn;
    logic [2:0]  cs;
    logic        ov;
    logic        it;
    logic        bi;
    logic [1:0]  bc;
    logic        ae;
    logic        be;
  } out_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] exe;
    logic [31:0] busB;
    logic [3:0]  rd;
    logic [3:0]  wr;
    logic        ls;
    logic        m2r;
    logic        rw;
    logic [4:0]  rn;
    logic        cw;
    logic [4:0]  cn;
    logic [2:0]  cs;
    logic        ov;
    logic        it;
    logic        bi;
    logic [1:0]  bc;
  } instr_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic write = 1'b0;
  logic flush = 1'b0;
  logic [31:0] pc = '0, exe_data = '0, busB = '0;
  logic [3:0]  memReadEn = '0, memWriteEn = '0;
  logic load_signed = 0, mem_to_reg = 0, reg_wen = 0;
  logic [4:0] reg_num = '0, cp0_num = '0;
  logic cp0_wen = 0, overflow = 0, Int = 0, bad_inst = 0;
  logic [2:0] cp0_sel = '0;
  logic [1:0] bc_inst = '0;
  logic stall_out;
  logic [31:0] pc_out, wb_data_out;
  logic reg_wen_out, cp0_wen_out, overflow_out, Int_out;
  logic bad_inst_out, addr_err_out, bus_err_out;
  logic [4:0] reg_num_out, cp0_num_out;
  logic [2:0] cp0_sel_out;
  logic [1:0] bc_inst_out;

  mem_stage_if dm();

  mem_stage #(.MAX_WAIT(MAXW)) dut (
    .clk(clk), .rst(rst), .write(write), .flush(flush),
    .pc(pc), .exe_data(exe_data), .busB(busB),
    .memReadEn(memReadEn), .memWriteEn(memWriteEn),
    .load_signed(load_signed), .mem_to_reg(mem_to_reg),
    .reg_wen(reg_wen), .reg_num(reg_num),
    .cp0_wen(cp0_wen), .cp0_num(cp0_num), .cp0_sel(cp0_sel),
    .overflow(overflow), .Int(Int), .bad_inst(bad_inst),
    .bc_inst(bc_inst), .dm(dm), .stall_out(stall_out),
    .pc_out(pc_out), .wb_data_out(wb_data_out),
    .reg_wen_out(reg_wen_out), .reg_num_out(reg_num_out),
    .cp0_wen_out(cp0_wen_out), .cp0_num_out(cp0_num_out),
    .cp0_sel_out(cp0_sel_out), .overflow_out(overflow_out),
    .Int_out(Int_out), .bad_inst_out(bad_inst_out),
    .bc_inst_out(bc_inst_out), .addr_err_out(addr_err_out),
    .bus_err_out(bus_err_out)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;
  out_t cur, last;
  out_t expq[$];
  logic [31:0] em [64];
  logic [31:0] mm [64];
  int lat = 0, ecnt = 0, tid = 0, mtid = 0;
  bit spur = 1'b0;

  assign cur = {pc_out, wb_data_out, reg_wen_out, reg_num_out,
                cp0_wen_out, cp0_num_out, cp0_sel_out,
                overflow_out, Int_out, bad_inst_out,
                bc_inst_out, addr_err_out, bus_err_out};

  assign dm.rdata = em[dm.addr[7:2]];

  // Memory acks after 'lat' request cycles of each transaction.
  always @(negedge clk) begin
    if (mtid != tid) begin
      mtid = tid;
      ecnt = 0;
    end
    if (!rst) begin
      dm.ack = 1'b0;
      ecnt = 0;
    end else if (dm.req) begin
      if (ecnt >= lat) begin
        dm.ack = 1'b1;
        ecnt = 0;
        for (int j = 0; j < 4; j++)
          if (dm.we[j])
            em[dm.addr[7:2]][8*j +: 8] = dm.wdata[8*j +: 8];
      end else begin
        dm.ack = 1'b0;
        ecnt++;
      end
    end else begin
      dm.ack = spur;
      ecnt = 0;
    end
  end

  function automatic void chk(string nm, logic [127:0] got,
                              logic [127:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got %h expected %h", nm, got, exp);
    end
  endfunction

  initial begin
    out_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("wb_bundle", 128'(cur), 128'(e));
      end
    end
  end

  task automatic apply(input instr_t t);
    pc = t.pc; exe_data = t.exe; busB = t.busB;
    memReadEn = t.rd; memWriteEn = t.wr;
    load_signed = t.ls; mem_to_reg = t.m2r;
    reg_wen = t.rw; reg_num = t.rn;
    cp0_wen = t.cw; cp0_num = t.cn; cp0_sel = t.cs;
    overflow = t.ov; Int = t.it; bad_inst = t.bi;
    bc_inst = t.bc;
    tid++;
  endtask

  task automatic model(input instr_t t, input int l,
                       input int fa, input bit w,
                       output bit mop, output int nst,
                       output out_t fin,
                       output logic [3:0] ewe,
                       output logic [31:0] ewd);
    int sz, off, idx;
    bit acc, ae, be, fw, kill;
    logic [3:0] m;
    logic [31:0] word, ld;
    logic [7:0] b;
    logic [15:0] h;
    acc = (t.rd | t.wr) != 0;
    m = (t.wr != 0) ? t.wr : t.rd;
    sz = (m == 4'b0001) ? 1 : (m == 4'b0011) ? 2 : 4;
    off = int'(t.exe[1:0]);
    idx = int'(t.exe[7:2]);
    ae = acc && (off % sz != 0);
    mop = acc && !ae && fa != 0 && !t.ov;
    nst = !mop ? 0 : (l < MAXW ? l : MAXW);
    be = mop && l > MAXW;
    fw = mop && fa >= 1 && fa <= nst;
    ewe = '0;
    for (int j = 0; j < 4; j++)
      ewd[8*j +: 8] = t.busB[8*(j % sz) +: 8];
    if (t.wr != 0 && mop)
      for (int i = 0; i < sz; i++) ewe[off + i] = 1'b1;
    word = mm[idx];
    b = word[8*off +: 8];
    h = word[16*(off / 2) +: 16];
    if (sz == 1)
      ld = t.ls ? {{24{b[7]}}, b} : {24'h0, b};
    else if (sz == 2)
      ld = t.ls ? {{16{h[15]}}, h} : {16'h0, h};
    else
      ld = word;
    if (mop && !be && t.wr != 0)
      for (int i = 0; i < sz; i++)
        mm[idx][8*(off + i) +: 8] = t.busB[8*i +: 8];
    kill = fa == 0 || t.ov || ae || be || fw;
    fin = '0;
    fin.pc = t.pc;
    fin.wb = (t.m2r && !be) ? ld : t.exe;
    fin.rw = t.rw && !kill;
    fin.rn = t.rn;
    fin.cw = t.cw && !kill;
    fin.cn = t.cn;
    fin.cs = t.cs;
    fin.ov = t.ov;
    fin.it = t.it;
    fin.bi = t.bi;
    fin.bc = t.bc;
    fin.ae = ae;
    fin.be = be;
    if (nst > 0) last = '0;
    if (!w) fin = last;
    last = fin;
  endtask

  task automatic run(input instr_t t, input int l,
                     input int fa, input bit w);
    bit mop;
    int nst;
    out_t fin;
    logic [3:0] ewe;
    logic [31:0] ewd;
    model(t, l, fa, w, mop, nst, fin, ewe, ewd);
    for (int c = 0; c <= nst; c++) begin
      if (c == 0) begin
        lat = l;
        apply(t);
        write = w;
      end
      flush = (fa == c);
      @(negedge clk);
      #1;
      chk("stall_out", 128'(stall_out), 128'(c < nst));
      chk("dm_req", 128'(dm.req), 128'(mop));
      if (mop) begin
        chk("dm_addr", 128'(dm.addr), 128'({t.exe[31:2], 2'b00}));
        chk("dm_we", 128'(dm.we), 128'(ewe));
        chk("dm_wdata", 128'(dm.wdata), 128'(ewd));
      end
      expq.push_back(c < nst ? out_t'('0) : fin);
      @(posedge clk);
      #1;
    end
    flush = 1'b0;
  endtask

  function automatic instr_t blank();
    instr_t t;
    t = '0;
    return t;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    instr_t t;
    int l, fa, r;
    bit w;
    logic [3:0] m;
    last = '0;
    for (int i = 0; i < 64; i++) begin
      em[i] = $urandom;
      mm[i] = em[i];
    end
    t = blank();
    t.exe = 32'h40;
    t.wr = 4'b1111;
    apply(t);
    write = 1'b1;
    #2;
    chk("rst_req", 128'(dm.req), 128'(0));
    chk("rst_we", 128'(dm.we), 128'(0));
    chk("rst_stall", 128'(stall_out), 128'(0));
    chk("rst_out", 128'(cur), 128'(0));
    apply(blank());
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    em[0] = 32'h8012_3456;
    mm[0] = em[0];
    t = blank();
    t.pc = 32'h100; t.exe = 32'h1003; t.rd = 4'b0001;
    t.ls = 1; t.m2r = 1; t.rw = 1; t.rn = 5'd5;
    run(t, 0, -1, 1);
    chk("sb_load_wb", 128'(wb_data_out), 128'(32'hFFFF_FF80));

    t = blank();
    t.pc = 32'h104; t.exe = 32'h2002; t.wr = 4'b0011;
    t.busB = 32'h1234_ABCD;
    run(t, 3, -1, 1);

    t = blank();
    t.pc = 32'h108; t.exe = 32'h0002; t.rd = 4'b1111;
    t.rw = 1; t.rn = 5'd7; t.m2r = 1;
    run(t, 0, -1, 1);
    chk("misalign_ae", 128'(addr_err_out), 128'(1));

    t = blank();
    t.pc = 32'h10c; t.exe = 32'h30; t.rd = 4'b1111;
    t.rw = 1; t.rn = 5'd9; t.m2r = 1;
    run(t, 99, -1, 1);
    chk("timeout_be", 128'(bus_err_out), 128'(1));
    t = blank();
    t.pc = 32'h110; t.exe = 32'h55; t.rw = 1; t.rn = 5'd3;
    spur = 1'b1;
    run(t, 0, -1, 1);
    spur = 1'b0;

    t = blank();
    t.pc = 32'h114; t.exe = 32'h34; t.rd = 4'b1111;
    t.rw = 1; t.cw = 1; t.rn = 5'd4; t.m2r = 1;
    run(t, 2, 1, 1);

    t = blank();
    t.pc = 32'h118; t.exe = 32'h80; t.rd = 4'b1111;
    t.rw = 1; t.rn = 5'd6; t.m2r = 1;
    lat = 99;
    apply(t);
    write = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      #1;
      chk("rw_stall", 128'(stall_out), 128'(1));
      expq.push_back(out_t'('0));
      @(posedge clk);
      #1;
    end
    chk("rw_req_wait", 128'(dm.req), 128'(1));
    rst = 1'b0;
    #1;
    chk("rw_req_drop", 128'(dm.req), 128'(0));
    chk("rw_stall_drop", 128'(stall_out), 128'(0));
    chk("rw_we", 128'(dm.we), 128'(0));
    chk("rw_out", 128'(cur), 128'(0));
    @(posedge clk);
    #1;
    apply(blank());
    @(negedge clk);
    rst = 1'b1;
    last = '0;
    @(posedge clk);
    #1;
    t = blank();
    t.pc = 32'h11c; t.exe = 32'h40; t.rd = 4'b1111;
    t.rw = 1; t.rn = 5'd8; t.m2r = 1;
    run(t, 1, -1, 1);

    for (int n = 0; n < 200; n++) begin
      t = blank();
      t.pc = $urandom;
      t.exe = $urandom;
      if ($urandom % 4 != 0) t.exe[1:0] = 2'b00;
      r = $urandom % 3;
      m = 4'b1111;
      if (r == 0) m = 4'b0001;
      if (r == 1) m = 4'b0011;
      r = $urandom % 3;
      if (r == 1) t.rd = m;
      if (r == 2) t.wr = m;
      t.busB = $urandom;
      t.ls = 1'($urandom);
      t.m2r = (r == 1) || (r == 0 && $urandom % 4 == 0);
      t.rw = 1'($urandom);
      t.rn = 5'($urandom);
      t.cw = 1'($urandom);
      t.cn = 5'($urandom);
      t.cs = 3'($urandom);
      t.ov = ($urandom % 16) == 0;
      t.it = 1'($urandom);
      t.bi = 1'($urandom);
      t.bc = 2'($urandom);
      l = $urandom % 7;
      r = $urandom % 10;
      fa = -1;
      if (r == 0) fa = 0;
      if (r == 1) fa = 1 + $urandom % 3;
      w = ($urandom % 10) != 0;
      run(t, l, fa, w);
    end

    repeat (3) @(posedge clk);
    #2;
    chk("queue_drained", 128'(expq.size()), 128'(0));
    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end
endmodule
